// File: rtl/a2600_clock_scheduler_if.sv
// a2600_clock_scheduler_if
//   Groups the scheduler's scanline/vsync inputs and its enable outputs.
//   master : the scheduler (samples VGA/TIA timing, drives the enables)
//   slave  : the consumer side (VGA sync generator / CPU, TIA, PIA glue)
//   vga_x[9:0]   current VGA hpos
//   vga_vsync    VGA vsync, active high
//   tia_vsync    TIA VSYNC register output
//   phase[4:0]   current phase, 0..DIV-1
//   clk_cpu      CPU clock level
//   cpu_en       one-clk pulse at phase 0
//   tia_en       pulse at the three TIA phases
//   pia_en       pulse at the PIA phase
//   frame_wait   machine held waiting for VGA vsync
//   lock_err     sticky: a wait ended by timeout
interface a2600_clock_scheduler_if;
  logic [9:0] vga_x;
  logic       vga_vsync;
  logic       tia_vsync;
  logic [4:0] phase;
  logic       clk_cpu;
  logic       cpu_en;
  logic       tia_en;
  logic       pia_en;
  logic       frame_wait;
  logic       lock_err;

  modport master (
    input  vga_x, vga_vsync, tia_vsync,
    output phase, clk_cpu, cpu_en, tia_en, pia_en, frame_wait, lock_err
  );

  modport slave (
    output vga_x, vga_vsync, tia_vsync,
    input  phase, clk_cpu, cpu_en, tia_en, pia_en, frame_wait, lock_err
  );
endinterface

// File: rtl/a2600_clock_scheduler.sv
// a2600_clock_scheduler
//   Derives the Atari 2600 clock enables (TIA colour clock, CPU clock, PIA
//   strobe) from the VGA pixel clock with a 21-step phase counter that is
//   re-aligned to phase 0 at the start of every VGA scanline.
//   Optional macro FRAME_LOCK_EN adds a frame-lock FSM that freezes the
//   machine after each TIA frame until the next VGA vsync rising edge.
//   Without the macro the machine free-runs, frame_wait=0, lock_err=0.
// Ports:
//   clk    VGA pixel clock
//   rst_n  synchronous active-low reset (also masks enables combinationally)
//   bus    a2600_clock_scheduler_if.master (timing inputs, enable outputs)
//
// state  | meaning
// RUN    | free running, enables decoded from phase
// DRAIN  | TIA frame ended, finishing the current machine cycle
// WAIT   | machine frozen at phase 0 until VGA vsync rise or timeout
module a2600_clock_scheduler #(
  parameter int DIV          = 21,
  parameter int SKIP_PIXELS  = 2,
  parameter int TIA_PH0      = 0,
  parameter int TIA_PH1      = 7,
  parameter int TIA_PH2      = 14,
  parameter int PIA_PH       = 16,
  parameter int CPU_HI       = 16,
  parameter int LOCK_TIMEOUT = 840000
) (
  input logic                    clk,
  input logic                    rst_n,
  a2600_clock_scheduler_if.master bus
);

  localparam logic [9:0] SKIP_X   = 10'(SKIP_PIXELS);
  localparam logic [4:0] PH_LAST  = 5'(DIV - 1);
  localparam logic [4:0] PH_TIA0  = 5'(TIA_PH0);
  localparam logic [4:0] PH_TIA1  = 5'(TIA_PH1);
  localparam logic [4:0] PH_TIA2  = 5'(TIA_PH2);
  localparam logic [4:0] PH_PIA   = 5'(PIA_PH);
  localparam logic [4:0] PH_CPUHI = 5'(CPU_HI);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t     state;
  logic [4:0] phase;
  logic [4:0] phase_adv;
  logic       en_ok;

  // Free-running advance; the first SKIP_PIXELS of each line pin the phase
  // to 0 so 1600 VGA clocks per line map onto 228*7 = 1596 counted ones.
  always_comb begin
    if (bus.vga_x < SKIP_X)
      phase_adv = '0;
    else if (phase == PH_LAST)
      phase_adv = '0;
    else
      phase_adv = phase + 5'd1;
  end

`ifdef FRAME_LOCK_EN
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(LOCK_TIMEOUT - 1);

  state_t        state_nxt;
  logic [4:0]    phase_nxt;
  logic [TW-1:0] timeout;
  logic [TW-1:0] timeout_nxt;
  logic          lock_err;
  logic          lock_err_nxt;
  logic          prev_tia_vsync;
  logic          prev_vga_vsync;
  logic          tia_fall;
  logic          vga_rise;

  assign tia_fall = prev_tia_vsync & ~bus.tia_vsync;
  assign vga_rise = ~prev_vga_vsync & bus.vga_vsync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_RUN;
      phase          <= '0;
      timeout        <= '0;
      lock_err       <= 1'b0;
      prev_tia_vsync <= 1'b0;
      prev_vga_vsync <= 1'b0;
    end else begin
      state          <= state_nxt;
      phase          <= phase_nxt;
      timeout        <= timeout_nxt;
      lock_err       <= lock_err_nxt;
      prev_tia_vsync <= bus.tia_vsync;
      prev_vga_vsync <= bus.vga_vsync;
    end
  end

  always_comb begin
    state_nxt    = state;
    phase_nxt    = phase_adv;
    timeout_nxt  = '0;
    lock_err_nxt = lock_err;
    case (state)
      ST_RUN: begin
        if (tia_fall)
          state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Leave only at a machine-cycle boundary so the CPU never sees a
        // truncated cycle; a line-start skip counts as a boundary too.
        if (phase_adv == '0)
          state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        phase_nxt = '0;
        if (vga_rise) begin
          state_nxt = ST_RUN;
        end else if (timeout == TO_LAST) begin
          state_nxt    = ST_RUN;
          lock_err_nxt = 1'b1;
        end else begin
          timeout_nxt = timeout + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_RUN;
        phase_nxt = '0;
      end
    endcase
  end
`else
  localparam int unused_lock_timeout = LOCK_TIMEOUT;
  logic          unused_vsync;

  assign state        = ST_RUN;
  assign unused_vsync = bus.tia_vsync ^ bus.vga_vsync;

  always_ff @(posedge clk) begin
    if (!rst_n)
      phase <= '0;
    else
      phase <= phase_adv;
  end
`endif

  always_comb begin
    en_ok          = rst_n && (state != ST_WAIT);
    bus.phase      = phase;
    bus.cpu_en     = en_ok && (phase == '0);
    bus.tia_en     = en_ok && ((phase == PH_TIA0) || (phase == PH_TIA1) ||
                               (phase == PH_TIA2));
    bus.pia_en     = en_ok && (phase == PH_PIA);
    bus.clk_cpu    = en_ok && (phase < PH_CPUHI);
    bus.frame_wait = (state == ST_WAIT);
`ifdef FRAME_LOCK_EN
    bus.lock_err   = lock_err;
`else
    bus.lock_err   = 1'b0;
`endif
  end

endmodule

// File: tb/tb_a2600_clock_scheduler.sv
module tb_a2600_clock_scheduler;

`ifdef FRAME_LOCK_EN
  localparam int TB_TO = 3000;
`else
  localparam int TB_TO = 840000;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  a2600_clock_scheduler_if sif ();

  a2600_clock_scheduler #(.LOCK_TIMEOUT(TB_TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [9:0] x;
    logic [4:0] ph;
    logic       cpu;
    logic       tia;
    logic       pia;
    logic       ck;
  } vec_t;

  vec_t vecs[14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    #1;
  endtask

`ifdef FRAME_LOCK_EN
  // Raise then drop tia_vsync at phase 5; returns clocks until frame_wait.
  task automatic enter_wait(output int n);
    int k;
    sif.tia_vsync = 1'b1;
    step();
    step();
    k = 0;
    while (sif.phase != 5'd5 && k < 40) begin
      step();
      k++;
    end
    sif.tia_vsync = 1'b0;
    n = 0;
    while (!sif.frame_wait && n < 40) begin
      step();
      n++;
    end
  endtask
`endif

  initial begin
    int cpu_cnt, tia_cnt, pia_cnt, ck_cnt, ph, n;

    rst_n         = 1'b0;
    sif.vga_x     = 10'd100;
    sif.vga_vsync = 1'b0;
    sif.tia_vsync = 1'b0;

    //             rst   x        ph    cpu   tia   pia   ck
    vecs[0]  = '{1'b0, 10'd100, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 10'd5,   5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 10'd100, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 10'd0,   5'd0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 10'd1,   5'd0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 10'd2,   5'd1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 10'd3,   5'd2, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 10'd4,   5'd3, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 10'd5,   5'd4, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 10'd6,   5'd5, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 10'd7,   5'd6, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 10'd8,   5'd7, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 10'd9,   5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 10'd0,   5'd0, 1'b1, 1'b1, 1'b0, 1'b1};

    #2;
    for (int i = 0; i < 14; i++) begin
      rst_n     = vecs[i].rst_n;
      sif.vga_x = vecs[i].x;
      step();
      check($sformatf("vec%0d_phase", i), sif.phase, vecs[i].ph);
      check($sformatf("vec%0d_cpu_en", i), sif.cpu_en, vecs[i].cpu);
      check($sformatf("vec%0d_tia_en", i), sif.tia_en, vecs[i].tia);
      check($sformatf("vec%0d_pia_en", i), sif.pia_en, vecs[i].pia);
      check($sformatf("vec%0d_clk_cpu", i), sif.clk_cpu, vecs[i].ck);
      check($sformatf("vec%0d_frame_wait", i), sif.frame_wait, 0);
      check($sformatf("vec%0d_lock_err", i), sif.lock_err, 0);
    end

    // Cadence: 42 clocks at a mid-line position.
    sif.vga_x = 10'd100;
    do_reset();
    cpu_cnt = 0; tia_cnt = 0; pia_cnt = 0; ck_cnt = 0;
    for (int i = 0; i < 42; i++) begin
      ph = i % 21;
      check("cad_phase", sif.phase, ph);
      check("cad_cpu_pos", sif.cpu_en, (ph == 0) ? 1 : 0);
      check("cad_tia_pos", sif.tia_en, (ph == 0 || ph == 7 || ph == 14) ? 1 : 0);
      check("cad_pia_pos", sif.pia_en, (ph == 16) ? 1 : 0);
      check("cad_ck_pos", sif.clk_cpu, (ph < 16) ? 1 : 0);
      cpu_cnt += int'(sif.cpu_en);
      tia_cnt += int'(sif.tia_en);
      pia_cnt += int'(sif.pia_en);
      ck_cnt  += int'(sif.clk_cpu);
      step();
    end
    check("cad_cpu_count", cpu_cnt, 2);
    check("cad_tia_count", tia_cnt, 6);
    check("cad_pia_count", pia_cnt, 2);
    check("cad_clk_high", ck_cnt, 32);

    // Line skip: sweep one full scanline.
    for (int k = 0; k < 800; k++) begin
      sif.vga_x = 10'(k);
      #1;
      if (k >= 1)
        check($sformatf("skip_x%0d", k), sif.phase, (k < 3) ? 0 : (k - 2) % 21);
      if (k == 799)
        check("skip_end_phase", sif.phase, 20);
      step();
    end
    sif.vga_x = 10'd100;

`ifdef FRAME_LOCK_EN
    // Frame lock with a vsync release 1000 clocks into WAIT.
    do_reset();
    enter_wait(n);
    check("lock_drain_len", n, 16);
    check("lock_wait_phase", sif.phase, 0);
    check("lock_wait_cpu_en", sif.cpu_en, 0);
    check("lock_wait_tia_en", sif.tia_en, 0);
    check("lock_wait_clk_cpu", sif.clk_cpu, 0);
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      if (!sif.frame_wait) n++;
      step();
    end
    check("lock_hold_drops", n, 0);
    sif.vga_vsync = 1'b1;
    step();
    check("lock_rel_frame_wait", sif.frame_wait, 0);
    check("lock_rel_phase", sif.phase, 0);
    check("lock_rel_cpu_en", sif.cpu_en, 1);
    check("lock_rel_tia_en", sif.tia_en, 1);
    check("lock_rel_lock_err", sif.lock_err, 0);
    step();
    check("lock_rel_next_phase", sif.phase, 1);
    sif.vga_vsync = 1'b0;

    // vsync rise during DRAIN is ignored; tia fall in WAIT is ignored.
    sif.tia_vsync = 1'b1;
    step();
    step();
    n = 0;
    while (sif.phase != 5'd5 && n < 40) begin step(); n++; end
    sif.tia_vsync = 1'b0;
    step();
    sif.vga_vsync = 1'b1;
    step();
    check("race_in_drain", sif.frame_wait, 0);
    n = 0;
    while (!sif.frame_wait && n < 40) begin step(); n++; end
    check("race_reach_wait", sif.frame_wait, 1);
    for (int i = 0; i < 50; i++) step();
    check("race_still_wait", sif.frame_wait, 1);
    sif.tia_vsync = 1'b1;
    step();
    sif.tia_vsync = 1'b0;
    step();
    step();
    check("race_tia_in_wait", sif.frame_wait, 1);
    check("race_tia_phase", sif.phase, 0);
    sif.vga_vsync = 1'b0;
    step();
    sif.vga_vsync = 1'b1;
    step();
    check("race_second_rise", sif.frame_wait, 0);
    sif.vga_vsync = 1'b0;

    // Reset while held.
    enter_wait(n);
    for (int i = 0; i < 10; i++) step();
    rst_n = 1'b0;
    step();
    check("rstw_frame_wait", sif.frame_wait, 0);
    check("rstw_phase", sif.phase, 0);
    check("rstw_cpu_en", sif.cpu_en, 0);
    check("rstw_tia_en", sif.tia_en, 0);
    check("rstw_clk_cpu", sif.clk_cpu, 0);
    rst_n = 1'b1;
    #1;
    check("rstw_release_cpu_en", sif.cpu_en, 1);

    // Timeout and sticky lock_err.
    enter_wait(n);
    n = 0;
    while (sif.frame_wait && n < TB_TO + 10) begin step(); n++; end
    check("to_wait_len", n, TB_TO);
    check("to_lock_err", sif.lock_err, 1);
    enter_wait(n);
    sif.vga_vsync = 1'b1;
    step();
    check("to_sticky_release", sif.frame_wait, 0);
    check("to_sticky_lock_err", sif.lock_err, 1);
    sif.vga_vsync = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    check("to_reset_clears", sif.lock_err, 0);
`else
    // Same event sequence as the frame-lock case: nothing may stall.
    do_reset();
    for (int i = 0; i < 1200; i++) begin
      if (i == 2)    sif.tia_vsync = 1'b1;
      if (i == 5)    sif.tia_vsync = 1'b0;
      if (i == 1005) sif.vga_vsync = 1'b1;
      check("free_phase", sif.phase, i % 21);
      check("free_cpu_en", sif.cpu_en, (i % 21 == 0) ? 1 : 0);
      check("free_frame_wait", sif.frame_wait, 0);
      check("free_lock_err", sif.lock_err, 0);
      step();
    end
    sif.vga_vsync = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/a2600_clock_scheduler.md
Name: a2600_clock_scheduler

Overview:
Generates the Atari 2600 clock enables (TIA colour clock, CPU clock, PIA strobe) from the 25.175 MHz VGA pixel clock using a 21-cycle phase counter. The counter is aligned to the VGA scanline. An optional frame-lock FSM holds the whole emulated machine after each TIA frame until the next VGA vsync, so the TIA frame rate tracks the VGA frame rate. It sits between the VGA sync generator and the CPU/TIA/PIA instances, and replaces their ad-hoc enable decode.

Parameters:
DIV, 21, VGA clocks per CPU machine cycle (3 TIA clocks x 7).
SKIP_PIXELS, 2, leading VGA pixels per line during which the phase is forced to 0 (228*7 = 1596 vs 1600).
TIA_PH0 / TIA_PH1 / TIA_PH2, 0 / 7 / 14, phases asserting tia_en.
PIA_PH, 16, phase asserting pia_en.
CPU_HI, 16, number of phases (0..CPU_HI-1) with clk_cpu high.
LOCK_TIMEOUT, 840000, max VGA clocks spent in WAIT before forced release (~2 VGA frames).

Ports:
clk  in  1  VGA pixel clock
rst_n  in  1  synchronous active-low reset
vga_x  in  10  current VGA hpos
vga_vsync  in  1  VGA vsync (active high)
tia_vsync  in  1  TIA VSYNC register output
phase  out  5  current phase, 0..DIV-1
clk_cpu  out  1  CPU clock (high for phases 0..CPU_HI-1)
cpu_en  out  1  one-clk pulse at phase 0
tia_en  out  1  pulse at TIA_PH0/1/2
pia_en  out  1  pulse at PIA_PH
frame_wait  out  1  high while the machine is held (DRAIN excluded, WAIT only)
lock_err  out  1  sticky: a WAIT ended by timeout

Behaviour:
- Reset (rst_n low at a clk edge):
  - Registers: phase=0, state=RUN, timeout=0, lock_err=0, prev_tia_vsync=0, prev_vga_vsync=0.
  - While rst_n is low, clk_cpu/cpu_en/tia_en/pia_en are forced 0 combinationally.
- Outputs are combinational decode of registered phase/state only; there is no combinational path from vga_x or the vsync inputs.
- Phase counter, in RUN and DRAIN:
  - next = 0 if vga_x < SKIP_PIXELS;
  - else next = 0 if phase == DIV-1;
  - else next = phase+1.
  - Widths: phase 5 bits; timeout counter $clog2(LOCK_TIMEOUT+1) bits.
- Enable decode, in RUN and DRAIN only:
  - cpu_en = (phase==0).
  - tia_en = phase in {TIA_PH0, TIA_PH1, TIA_PH2}.
  - pia_en = (phase==PIA_PH).
  - clk_cpu = (phase < CPU_HI).
  - Nominal cadence: 21-clk period, tia_en 3x, cpu_en/pia_en 1x.
  - Phase 0 is re-entered on every clk with vga_x < SKIP_PIXELS, so enables at phase 0 repeat during the skip window. This is intended.
- Edge detect: tia_fall = prev_tia_vsync & ~tia_vsync; vga_rise = ~prev_vga_vsync & vga_vsync. Both prev registers update every clk in every state.
- FSM (with FRAME_LOCK_EN):
  - RUN: on tia_fall, go to DRAIN.
  - DRAIN: enables continue normally. When next phase == 0 (wrap or skip), go to WAIT with phase=0. The current machine cycle always completes.
  - WAIT:
    - phase held at 0; all enables and clk_cpu = 0; frame_wait = 1; timeout increments each clk.
    - On vga_rise, go to RUN and clear timeout. The first enabled phase is 0 on the next clk.
    - Else if timeout == LOCK_TIMEOUT-1, go to RUN, clear timeout and set lock_err.
- Simultaneous and ignored events:
  - tia_fall in DRAIN or WAIT is ignored.
  - vga_rise in RUN or DRAIN is ignored, so the machine waits for the following VGA vsync.
  - vga_rise and the timeout on the same clk: take the vga_rise exit; lock_err is not set.
- Reset mid-DRAIN or mid-WAIT returns to RUN with phase 0 on the next clk; lock_err is cleared.

Optional Feature:
FRAME_LOCK_EN
- Defined: the RUN/DRAIN/WAIT FSM, timeout counter and lock_err are present as described.
- Undefined: state is permanently RUN, the machine free-runs, frame_wait=0 and lock_err=0. The edge-detect and timeout logic is not synthesised.

Test Plan:
1. Cadence: reset released, vga_x held at 100 for 42 clks -> cpu_en at phases 0 only (2 pulses, 21 apart); tia_en at phases 0,7,14 (6 pulses); pia_en at phase 16; clk_cpu high 16 of 21 clks.
2. Line skip: vga_x steps 0..799 -> phase forced 0 at x=0,1; at x=2 phase 0 advances to 1 at x=3; at x=799 phase == (797 mod 21) = 20.
3. Frame lock: tia_vsync 1->0 at phase 5 -> enables continue through phase 20, then frame_wait=1 and all enables 0. A vga_vsync rise 1000 clks later -> frame_wait drops; cpu_en and tia_en fire at phase 0 on the next clk.
4. Timeout: enter WAIT, no vga_vsync -> exactly 840000 clks in WAIT, then RUN and lock_err=1. lock_err stays 1 through a later normal frame; rst_n low for 1 clk clears it.
5. Race and ignore cases:
   - vga_vsync rises during DRAIN -> ignored; WAIT persists until the next rise.
   - tia_vsync falls in WAIT -> no state change.
6. Reset and macro-off:
   - rst_n low mid-WAIT -> next clk state RUN, phase 0, all enables 0 while rst_n is low.
   - FRAME_LOCK_EN undefined: repeat scenario 3 -> frame_wait never asserts and the cadence is uninterrupted.
